// File: rtl/blink_mem_arb_if.sv
// Memory-arbiter bus bundle: CPU request, LCD fetch request and the shared memory port.
// The arbiter takes the slave view; the requesters/testbench take the master view.
interface blink_mem_arb_if #(
    parameter int unsigned AW = 22
);
    logic          cpu_req;
    logic          cpu_rd;
    logic [AW-1:0] cpu_addr;
    logic          lcd_req;
    logic [AW-1:0] lcd_addr;
    logic [7:0]    mdi;
    logic [AW-1:0] ma;
    logic          moe_n;
    logic          mwe_n;
    logic          wait_n;
    logic          lcd_ack;
    logic [7:0]    lcd_data;
    logic          lcd_busy;

    modport slave (
        input  cpu_req, cpu_rd, cpu_addr, lcd_req, lcd_addr, mdi,
        output ma, moe_n, mwe_n, wait_n, lcd_ack, lcd_data, lcd_busy
    );

    modport master (
        output cpu_req, cpu_rd, cpu_addr, lcd_req, lcd_addr, mdi,
        input  ma, moe_n, mwe_n, wait_n, lcd_ack, lcd_data, lcd_busy
    );
endinterface

// File: rtl/blink_mem_arb.sv
// Memory arbiter between the Z80 and the LCD fetcher. The CPU has priority
// unless the LCD has waited LCD_MAXWAIT cycles; CPU cycles are never aborted.
module blink_mem_arb #(
    parameter int unsigned AW          = 22,
    parameter int unsigned LCD_CYC     = 2,
    parameter int unsigned LCD_MAXWAIT = 8
) (
    input logic            mck,
    input logic            rin_n,
    blink_mem_arb_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StCpu, StLcd} state_e;

    localparam logic [7:0] MaxWait = 8'(LCD_MAXWAIT);
    localparam logic [3:0] LcdLast = 4'(LCD_CYC - 1);

    state_e     r_state, w_state_nxt;
    logic [7:0] r_wcnt, w_wcnt_nxt;
    logic [3:0] r_lcnt, w_lcnt_nxt;
    logic [7:0] r_lcd_data, w_lcd_data_nxt;
    logic       r_ack, w_ack_nxt;
    logic       w_lreq;
    logic       w_sat;

    // The request is masked during the ack cycle so a slow requester cannot refetch.
    assign w_lreq = bus.lcd_req & ~r_ack;
    assign w_sat  = (r_wcnt == MaxWait);

    always_ff @(posedge mck or negedge rin_n) begin
        if (!rin_n) begin
            r_state    <= StIdle;
            r_wcnt     <= 8'd0;
            r_lcnt     <= 4'd0;
            r_lcd_data <= 8'h00;
            r_ack      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wcnt     <= w_wcnt_nxt;
            r_lcnt     <= w_lcnt_nxt;
            r_lcd_data <= w_lcd_data_nxt;
            r_ack      <= w_ack_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_lcnt_nxt     = r_lcnt;
        w_lcd_data_nxt = r_lcd_data;
        w_ack_nxt      = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_lreq && (!bus.cpu_req || w_sat)) begin
                    w_state_nxt = StLcd;
                    w_lcnt_nxt  = 4'd0;
                end else if (bus.cpu_req) begin
                    w_state_nxt = StCpu;
                end
            end
            StCpu: begin
                if (!bus.cpu_req) begin
                    w_state_nxt = StIdle;
                end
            end
            StLcd: begin
                w_lcnt_nxt = r_lcnt + 4'd1;
                if (r_lcnt == LcdLast) begin
                    w_lcd_data_nxt = bus.mdi;
                    w_state_nxt    = StIdle;
                    w_ack_nxt      = 1'b1;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // Wait counter clears on LCD entry; otherwise it counts pending cycles and saturates.
    always_comb begin
        w_wcnt_nxt = r_wcnt;
        if (r_state == StIdle && w_state_nxt == StLcd) begin
            w_wcnt_nxt = 8'd0;
        end else if (w_lreq && r_state != StLcd && !w_sat) begin
            w_wcnt_nxt = r_wcnt + 8'd1;
        end
    end

    always_comb begin
        bus.ma    = '1;
        bus.moe_n = 1'b1;
        bus.mwe_n = 1'b1;
        case (r_state)
            StCpu: begin
                bus.ma    = bus.cpu_addr;
                bus.moe_n = ~bus.cpu_rd;
                bus.mwe_n = bus.cpu_rd;
            end
            StLcd: begin
                bus.ma    = bus.lcd_addr;
                bus.moe_n = 1'b0;
            end
            default: ;
        endcase
    end

    assign bus.wait_n   = ~(bus.cpu_req && r_state != StCpu);
    assign bus.lcd_busy = (r_state == StLcd);
    assign bus.lcd_ack  = r_ack;
    assign bus.lcd_data = r_lcd_data;

endmodule

// File: tb/tb_blink_mem_arb.sv
// Directed bench for blink_mem_arb: per-cycle bus checks plus a queue-based
// scoreboard that matches every lcd_ack pulse against the expected fetched byte.
module tb_blink_mem_arb;
    localparam int unsigned AW = 22;
    localparam int ST_I = 0;
    localparam int ST_C = 1;
    localparam int ST_L = 2;

    logic mck;
    logic rin_n;
    int   n_tests;
    int   n_fail;
    logic [7:0] exp_q[$];

    blink_mem_arb_if #(.AW(AW)) bus ();

    blink_mem_arb #(
        .AW(AW),
        .LCD_CYC(2),
        .LCD_MAXWAIT(8)
    ) dut (
        .mck(mck),
        .rin_n(rin_n),
        .bus(bus)
    );

    initial mck = 1'b0;
    always #5 mck = ~mck;

    // Scoreboard monitor: every ack must match the oldest expected byte.
    always @(negedge mck) begin
        if (bus.lcd_ack === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL ack_unexpected: lcd_ack=1 data=%h, required no ack", bus.lcd_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (bus.lcd_data !== e) begin
                    n_fail++;
                    $display("FAIL ack_data: lcd_data=%h, required %h", bus.lcd_data, e);
                end
            end
        end
    end

    // Expected bus outputs from the intended state and the current inputs.
    task automatic chk_st(input string nm, input int st);
        logic [AW-1:0] e_ma;
        logic e_oe, e_we, e_wait, e_busy;
        e_ma = '1;
        e_oe = 1'b1;
        e_we = 1'b1;
        if (st == ST_C) begin
            e_ma = bus.cpu_addr;
            e_oe = ~bus.cpu_rd;
            e_we = bus.cpu_rd;
        end else if (st == ST_L) begin
            e_ma = bus.lcd_addr;
            e_oe = 1'b0;
        end
        e_wait = ~(bus.cpu_req && st != ST_C);
        e_busy = (st == ST_L);
        n_tests++;
        if (bus.ma !== e_ma || bus.moe_n !== e_oe || bus.mwe_n !== e_we ||
            bus.wait_n !== e_wait || bus.lcd_busy !== e_busy) begin
            n_fail++;
            $display("FAIL %s: ma=%h oe_n=%b we_n=%b wait_n=%b busy=%b, required %h %b %b %b %b",
                     nm, bus.ma, bus.moe_n, bus.mwe_n, bus.wait_n, bus.lcd_busy,
                     e_ma, e_oe, e_we, e_wait, e_busy);
        end
    endtask

    task automatic chk_bits(input string nm, input logic [7:0] act, input logic [7:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    // One cycle: inputs already driven just after the previous posedge.
    task automatic cyc(input string nm, input int st);
        @(negedge mck);
        chk_st(nm, st);
        @(posedge mck);
        #1;
    endtask

    logic tbl_cpu [14];
    int   tbl_st  [14];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rin_n        = 1'b0;
        bus.cpu_req  = 1'b1;
        bus.cpu_rd   = 1'b1;
        bus.cpu_addr = 22'h000100;
        bus.lcd_req  = 1'b0;
        bus.lcd_addr = 22'h000000;
        bus.mdi      = 8'h00;

        // Reset state; wait_n still follows cpu_req while in reset.
        @(negedge mck);
        chk_st("reset_cpu_req", ST_I);
        chk_bits("reset_lcd_data", bus.lcd_data, 8'h00);
        chk_bits("reset_lcd_ack", {7'd0, bus.lcd_ack}, 8'h00);
        bus.cpu_req = 1'b0;
        @(posedge mck);
        #1;
        rin_n = 1'b1;
        cyc("post_reset_idle", ST_I);

        // Plain LCD fetch; a request held through the ack cycle must not refetch.
        bus.lcd_req  = 1'b1;
        bus.lcd_addr = 22'h012345;
        bus.mdi      = 8'hA5;
        exp_q.push_back(8'hA5);
        cyc("lcd_grant", ST_I);
        cyc("lcd_cyc0", ST_L);
        cyc("lcd_cyc1", ST_L);
        cyc("lcd_ack_cycle", ST_I);
        bus.lcd_req = 1'b0;
        cyc("lcd_no_refetch", ST_I);
        chk_bits("lcd_data_a5", bus.lcd_data, 8'hA5);

        // CPU write then read in the same cycle.
        bus.cpu_req  = 1'b1;
        bus.cpu_rd   = 1'b0;
        bus.cpu_addr = 22'h200010;
        cyc("cpu_wait", ST_I);
        cyc("cpu_write", ST_C);
        bus.cpu_rd = 1'b1;
        cyc("cpu_read", ST_C);
        bus.cpu_req = 1'b0;
        cyc("cpu_end", ST_C);
        cyc("cpu_idle", ST_I);

        // Simultaneous requests with wcnt=0: CPU wins, LCD follows.
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 22'h000100;
        bus.lcd_req  = 1'b1;
        bus.lcd_addr = 22'h03ABCD;
        bus.mdi      = 8'h5A;
        exp_q.push_back(8'h5A);
        cyc("tie_idle", ST_I);
        cyc("tie_cpu0", ST_C);
        cyc("tie_cpu1", ST_C);
        bus.cpu_req = 1'b0;
        cyc("tie_cpu_end", ST_C);
        cyc("tie_idle2", ST_I);
        cyc("tie_lcd0", ST_L);
        cyc("tie_lcd1", ST_L);
        bus.lcd_req = 1'b0;
        cyc("tie_ack", ST_I);

        // Back-to-back CPU cycles with LCD pending: preemption once wcnt reaches 8.
        tbl_cpu = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                    1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl_st  = '{ST_I, ST_C, ST_C, ST_I, ST_C, ST_C, ST_I, ST_C, ST_C,
                    ST_I, ST_L, ST_L, ST_I, ST_C};
        bus.lcd_req  = 1'b1;
        bus.lcd_addr = 22'h001234;
        bus.mdi      = 8'hC3;
        exp_q.push_back(8'hC3);
        for (int i = 0; i < 14; i++) begin
            bus.cpu_req = tbl_cpu[i];
            cyc($sformatf("starve_%0d", i), tbl_st[i]);
        end
        bus.cpu_req = 1'b0;
        bus.lcd_req = 1'b0;
        cyc("starve_cpu_end", ST_C);
        cyc("starve_idle", ST_I);

        // lcd_req dropped in the first LCD cycle: fetch still completes.
        bus.lcd_req  = 1'b1;
        bus.lcd_addr = 22'h0ABCDE;
        bus.mdi      = 8'h3C;
        exp_q.push_back(8'h3C);
        cyc("drop_grant", ST_I);
        bus.lcd_req = 1'b0;
        cyc("drop_lcd0", ST_L);
        cyc("drop_lcd1", ST_L);
        cyc("drop_ack", ST_I);
        cyc("drop_idle", ST_I);
        chk_bits("drop_lcd_data", bus.lcd_data, 8'h3C);

        // Reset during the first LCD cycle aborts with no ack; refetch one cycle after release.
        bus.lcd_req  = 1'b1;
        bus.lcd_addr = 22'h155555;
        bus.mdi      = 8'h99;
        cyc("rst_grant", ST_I);
        @(negedge mck);
        chk_st("rst_lcd0", ST_L);
        rin_n = 1'b0;
        #1;
        chk_st("rst_abort", ST_I);
        chk_bits("rst_lcd_data", bus.lcd_data, 8'h00);
        chk_bits("rst_lcd_ack", {7'd0, bus.lcd_ack}, 8'h00);
        @(posedge mck);
        #1;
        rin_n = 1'b1;
        cyc("rst_release", ST_I);
        exp_q.push_back(8'h99);
        cyc("rst_refetch0", ST_L);
        cyc("rst_refetch1", ST_L);
        bus.lcd_req = 1'b0;
        cyc("rst_ack", ST_I);
        cyc("rst_idle", ST_I);

        repeat (3) cyc("tail_idle", ST_I);
        chk_bits("acks_outstanding", 8'(exp_q.size()), 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
